// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int unsigned BIN_W  = 13,
  parameter int unsigned DIGITS = 4
) ();

  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic                  ovf;
  logic [4*DIGITS-1:0]   bcd;

  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  ovf,
    input  bcd
  );

  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output ovf,
    output bcd
  );

endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with optional
// leading-zero blanking (blank digits emitted as 4'hF for a seven-seg decoder).
module bin_to_bcd_seq #(
  parameter int unsigned BIN_W    = 13,
  parameter int unsigned DIGITS   = 4,
  parameter bit          BLANK_LZ = 1'b1
) (
  input logic              clk,
  input logic              reset_n,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int unsigned CntW = $clog2(BIN_W + 1);
  localparam int unsigned BcdW = 4 * DIGITS;
  localparam logic [CntW-1:0] LastCnt = CntW'(BIN_W - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [BIN_W-1:0]  shift_q;
  logic [BcdW-1:0]   scr_q;
  logic              ovf_scr_q;
  logic              busy_q;
  logic              done_q;
  logic              ovf_q;
  logic [BcdW-1:0]   bcd_q;

  logic [BcdW-1:0]   adj;
  logic [BcdW-1:0]   scr_d;
  logic [BIN_W-1:0]  shift_d;
  logic              carry;
  logic              ovf_scr_d;
  logic [BcdW-1:0]   bcd_fin;
  logic              seen;

  // One iteration: add 3 to every digit >= 5, then shift {scratch, shift} left.
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
    {carry, scr_d, shift_d} = {adj, shift_q, 1'b0};
    // A bit leaving the top digit means the value no longer fits.
    ovf_scr_d = ovf_scr_q | carry;
  end

  // Blank digits above the most significant nonzero one; digit 0 always shown.
  always_comb begin
    bcd_fin = scr_d;
    seen    = ovf_scr_d | ~BLANK_LZ;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (scr_d[4*i +: 4] != 4'd0) begin
        seen = 1'b1;
      end
      if (!seen) begin
        bcd_fin[4*i +: 4] = 4'hF;
      end
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      scr_q     <= '0;
      ovf_scr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            shift_q   <= bus.bin;
            scr_q     <= '0;
            ovf_scr_q <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= StShift;
          end
        end
        StShift: begin
          shift_q   <= shift_d;
          scr_q     <= scr_d;
          ovf_scr_q <= ovf_scr_d;
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            bcd_q   <= bcd_fin;
            ovf_q   <= ovf_scr_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
  assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: three instances (default, no blanking,
// three digits) share one start/bin stimulus and are checked on every result.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [12:0] bin = '0;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] prev_a = '0;

  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.BIN_W(13), .DIGITS(4)) bus_a ();
  bin_to_bcd_seq_if #(.BIN_W(13), .DIGITS(4)) bus_b ();
  bin_to_bcd_seq_if #(.BIN_W(13), .DIGITS(3)) bus_c ();

  assign bus_a.start = start;
  assign bus_b.start = start;
  assign bus_c.start = start;
  assign bus_a.bin   = bin;
  assign bus_b.bin   = bin;
  assign bus_c.bin   = bin;

  bin_to_bcd_seq #(.BIN_W(13), .DIGITS(4), .BLANK_LZ(1'b1)) u_dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  bin_to_bcd_seq #(.BIN_W(13), .DIGITS(4), .BLANK_LZ(1'b0)) u_dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  bin_to_bcd_seq #(.BIN_W(13), .DIGITS(3), .BLANK_LZ(1'b1)) u_dut_c (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_c)
  );

  typedef struct {
    logic [12:0] v;
    logic [15:0] a;
    logic [15:0] b;
    logic [11:0] c;
    logic        oc;
  } vec_t;

  vec_t vecs[7] = '{
    '{13'd1234, 16'h1234, 16'h1234, 12'h234, 1'b1},
    '{13'd0,    16'hFFF0, 16'h0000, 12'hFF0, 1'b0},
    '{13'd905,  16'hF905, 16'h0905, 12'h905, 1'b0},
    '{13'd5,    16'hFFF5, 16'h0005, 12'hFF5, 1'b0},
    '{13'd999,  16'hF999, 16'h0999, 12'h999, 1'b0},
    '{13'd10,   16'hFF10, 16'h0010, 12'hF10, 1'b0},
    '{13'd8191, 16'h8191, 16'h8191, 12'h191, 1'b1}
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Independent decimal model of the default (4 digits, blanking) instance.
  function automatic logic [15:0] model(input int v);
    int d[4];
    logic [15:0] r;
    bit seen;
    d[0] = v % 10;
    d[1] = (v / 10) % 10;
    d[2] = (v / 100) % 10;
    d[3] = (v / 1000) % 10;
    seen = 1'b0;
    r = '0;
    for (int i = 3; i >= 1; i--) begin
      if (d[i] != 0) seen = 1'b1;
      r[4*i +: 4] = seen ? 4'(d[i]) : 4'hF;
    end
    r[3:0] = 4'(d[0]);
    return r;
  endfunction

  // Start one conversion; scrambles bin and pulses start while busy, both of
  // which must be ignored. Returns edges from accept (E0 counts as 1) to done.
  task automatic run(input logic [12:0] v, output int lat);
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = ~v;
    lat   = 1;
    check("busy_after_e0", 32'(bus_a.busy), 32'd1);
    while (!bus_a.done && lat < 40) begin
      if (lat == 4) start = 1'b1;
      if (lat == 5) start = 1'b0;
      if (lat == 6) check("bcd_hold", 32'(bus_a.bcd), 32'(prev_a));
      @(posedge clk);
      #1;
      lat++;
    end
    check("done_seen", 32'(bus_a.done), 32'd1);
    check("latency", 32'(lat), 32'd14);
    check("busy_in_done", 32'(bus_a.busy), 32'd0);
  endtask

  initial begin
    int lat;
    int n;
    logic [12:0] rv;

    #12;
    check("rst_busy", 32'(bus_a.busy), 32'd0);
    check("rst_done", 32'(bus_a.done), 32'd0);
    check("rst_ovf", 32'(bus_a.ovf), 32'd0);
    check("rst_bcd", 32'(bus_a.bcd), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[k]) begin
      run(vecs[k].v, lat);
      check($sformatf("bcd_a_%0d", vecs[k].v), 32'(bus_a.bcd), 32'(vecs[k].a));
      check($sformatf("ovf_a_%0d", vecs[k].v), 32'(bus_a.ovf), 32'd0);
      check($sformatf("bcd_b_%0d", vecs[k].v), 32'(bus_b.bcd), 32'(vecs[k].b));
      check($sformatf("bcd_c_%0d", vecs[k].v), 32'(bus_c.bcd), 32'(vecs[k].c));
      check($sformatf("ovf_c_%0d", vecs[k].v), 32'(bus_c.ovf), 32'(vecs[k].oc));
      prev_a = vecs[k].a;
      @(posedge clk);
      #1;
      check("done_width", 32'(bus_a.done), 32'd0);
    end

    // Reset in the middle of a conversion.
    @(negedge clk);
    bin   = 13'd1234;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus_a.busy), 32'd0);
    check("midrst_done", 32'(bus_a.done), 32'd0);
    check("midrst_bcd", 32'(bus_a.bcd), 32'h0);
    check("midrst_ovf_c", 32'(bus_c.ovf), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_idle", 32'(bus_a.busy), 32'd0);
    prev_a = 16'h0000;
    run(13'd42, lat);
    check("bcd_after_rst", 32'(bus_a.bcd), 32'hFF42);
    prev_a = 16'hFF42;

    // Start held high: back-to-back conversions of 7 then 99.
    @(negedge clk);
    bin   = 13'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    bin = 13'd99;
    n = 1;
    while (!bus_a.done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("b2b_lat1", 32'(n), 32'd14);
    check("b2b_bcd1", 32'(bus_a.bcd), 32'hFFF7);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) check("b2b_restart", 32'(bus_a.busy), 32'd1);
    end while (!bus_a.done && n < 40);
    start = 1'b0;
    check("b2b_period", 32'(n), 32'd14);
    check("b2b_bcd2", 32'(bus_a.bcd), 32'hFF99);
    check("b2b_bcd2_c", 32'(bus_c.bcd), 32'hF99);
    @(posedge clk);
    #1;
    check("b2b_done_width", 32'(bus_a.done), 32'd0);
    check("b2b_no_third", 32'(bus_a.busy), 32'd0);
    prev_a = 16'hFF99;

    // A few random values against the decimal model.
    for (int r = 0; r < 4; r++) begin
      rv = 13'($urandom_range(0, 8191));
      run(rv, lat);
      check($sformatf("rand_bcd_%0d", rv), 32'(bus_a.bcd), 32'(model(int'(rv))));
      prev_a = model(int'(rv));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
